// File: rtl/hack_fetch_pc_if.sv
// Fetch-stage bus bundle: the ROM request/ack channel and the
// instruction valid/ready channel towards decode.
interface hack_fetch_pc_if #(
    parameter int WIDTH = 16
);
    logic             rom_req;
    logic [WIDTH-1:0] rom_addr;
    logic             rom_ack;
    logic [WIDTH-1:0] rom_data;
    logic             inst_valid;
    logic [WIDTH-1:0] inst_data;
    logic [WIDTH-1:0] inst_pc;
    logic             inst_ready;

    // Fetch stage side
    modport master (
        output rom_req, rom_addr, inst_valid, inst_data, inst_pc,
        input  rom_ack, rom_data, inst_ready
    );

    // ROM / decode side
    modport slave (
        input  rom_req, rom_addr, inst_valid, inst_data, inst_pc,
        output rom_ack, rom_data, inst_ready
    );
endinterface

// File: rtl/hack_fetch_pc.sv
// Hack CPU program counter and instruction fetch stage. Holds the PC,
// fetches from instruction ROM over req/ack and buffers one instruction
// for decode over valid/ready. Jumps from execute redirect the PC; a jump
// that lands on an outstanding request parks in DRAIN until the stale
// ack has been swallowed.
module hack_fetch_pc #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_addr,
    hack_fetch_pc_if.master  bus
);
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic             busy;
    logic             inst_valid_q;
    logic [WIDTH-1:0] inst_data_q;
    logic [WIDTH-1:0] inst_pc_q;
    logic             rom_req;
    logic             ack_ok;
    logic             xfer;

    // Request whenever the slot can take a word or a request is already
    // outstanding; gated by rst_n so reset kills the request immediately.
    always_comb begin
        rom_req = 1'b0;
        if (state == S_DRAIN) begin
            rom_req = 1'b1;
        end else begin
            rom_req = busy | ~inst_valid_q | bus.inst_ready;
        end
        rom_req = rom_req & rst_n;
    end

    // An ack only counts against a live request; stray acks are ignored.
    assign ack_ok = rom_req & bus.rom_ack;
    assign xfer   = inst_valid_q & bus.inst_ready;

    assign bus.rom_req    = rom_req;
    assign bus.rom_addr   = pc;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;

    // PC, request tracking, redirect FSM and the output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_VECTOR;
            target       <= '0;
            busy         <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            if (ack_ok) begin
                busy <= 1'b0;
            end else if (rom_req) begin
                busy <= 1'b1;
            end

            case (state)
                S_FETCH: begin
                    if (jump_en) begin
                        // Flush the slot; a same-cycle ack is dropped.
                        inst_valid_q <= 1'b0;
                        if (rom_req && !bus.rom_ack) begin
                            target <= jump_addr;
                            state  <= S_DRAIN;
                        end else begin
                            pc <= jump_addr;
                        end
                    end else if (ack_ok) begin
                        inst_data_q  <= bus.rom_data;
                        inst_pc_q    <= pc;
                        inst_valid_q <= 1'b1;
                        pc           <= pc + WIDTH'(1);
                    end else if (xfer) begin
                        inst_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    inst_valid_q <= 1'b0;
                    if (ack_ok) begin
                        pc    <= jump_en ? jump_addr : target;
                        state <= S_FETCH;
                    end else if (jump_en) begin
                        target <= jump_addr;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_fetch_pc.sv
// Directed bench for hack_fetch_pc with a ROM model of programmable
// latency (data = addr ^ 16'hA5A5).
module tb_hack_fetch_pc;
    logic        clk;
    logic        rst_n;
    logic        jump_en;
    logic [15:0] jump_addr;
    int          lat;
    int          cnt;
    logic        force_ack;
    int          errors;
    int          checks;

    hack_fetch_pc_if #(.WIDTH(16)) bus ();

    hack_fetch_pc #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: acks once the request has been waiting lat cycles.
    always_comb begin
        bus.rom_ack  = force_ack | (bus.rom_req && (cnt >= lat));
        bus.rom_data = bus.rom_addr ^ 16'hA5A5;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
        end else if (bus.rom_req && !bus.rom_ack) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        jump_en = 1'b0;
        jump_addr = 16'h0000;
        bus.inst_ready = 1'b1;
        lat = 0;
        force_ack = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_req", bus.rom_req, 0);
        chk("rst_data", bus.inst_data, 0);
        chk("rst_pc", bus.inst_pc, 0);

        // Zero-wait streaming from the reset vector
        rst_n = 1'b1;
        #1;
        chk("first_req", bus.rom_req, 1);
        chk("first_addr", bus.rom_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", bus.inst_valid, 1);
            chk("stream_pc", bus.inst_pc, 32'(i));
            chk("stream_data", bus.inst_data, 32'(16'(i) ^ 16'hA5A5));
        end
        tick();
        tick();
        chk("pre_bp_pc", bus.inst_pc, 16'h0005);

        // Backpressure: slot holds, no request, pc parked at 6
        bus.inst_ready = 1'b0;
        #1;
        chk("bp_req", bus.rom_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", bus.inst_valid, 1);
            chk("bp_pc", bus.inst_pc, 16'h0005);
            chk("bp_data", bus.inst_data, 16'h0005 ^ 16'hA5A5);
            chk("bp_req_hold", bus.rom_req, 0);
            chk("bp_addr", bus.rom_addr, 16'h0006);
        end
        bus.inst_ready = 1'b1;
        #1;
        chk("bp_release_req", bus.rom_req, 1);
        tick();
        chk("bp_next_pc", bus.inst_pc, 16'h0006);
        chk("bp_next_valid", bus.inst_valid, 1);

        // Jump onto an outstanding slow request at address 7
        lat = 3;
        #1;
        chk("slow_req", bus.rom_req, 1);
        chk("slow_addr", bus.rom_addr, 16'h0007);
        tick();
        chk("slow_valid0", bus.inst_valid, 0);
        chk("slow_addr0", bus.rom_addr, 16'h0007);
        jump_en = 1'b1;
        jump_addr = 16'h0100;
        #1;
        chk("slow_req_jump", bus.rom_req, 1);
        tick();
        jump_en = 1'b0;
        chk("drain_addr1", bus.rom_addr, 16'h0007);
        chk("drain_valid1", bus.inst_valid, 0);
        tick();
        chk("drain_addr2", bus.rom_addr, 16'h0007);
        chk("drain_valid2", bus.inst_valid, 0);
        tick();
        chk("drain_discard", bus.inst_valid, 0);
        chk("redirect_addr", bus.rom_addr, 16'h0100);
        chk("redirect_req", bus.rom_req, 1);
        lat = 0;
        tick();
        chk("redirect_valid", bus.inst_valid, 1);
        chk("redirect_pc", bus.inst_pc, 16'h0100);
        chk("redirect_data", bus.inst_data, 16'h0100 ^ 16'hA5A5);

        // Multiple jumps while draining: last one wins
        lat = 5;
        tick();
        chk("multi_valid0", bus.inst_valid, 0);
        jump_en = 1'b1;
        jump_addr = 16'h0150;
        tick();
        jump_addr = 16'h0200;
        tick();
        jump_addr = 16'h0300;
        tick();
        jump_en = 1'b0;
        chk("multi_addr_hold", bus.rom_addr, 16'h0101);
        chk("multi_valid", bus.inst_valid, 0);
        tick();
        chk("multi_addr_hold2", bus.rom_addr, 16'h0101);
        tick();
        chk("multi_resume_addr", bus.rom_addr, 16'h0300);
        chk("multi_resume_valid", bus.inst_valid, 0);
        lat = 0;
        tick();
        chk("multi_pc", bus.inst_pc, 16'h0300);
        chk("multi_data", bus.inst_data, 16'h0300 ^ 16'hA5A5);

        // PC wrap; the jump lands on a same-cycle ack which is dropped
        jump_en = 1'b1;
        jump_addr = 16'hFFFF;
        tick();
        jump_en = 1'b0;
        chk("wrap_flush", bus.inst_valid, 0);
        chk("wrap_addr", bus.rom_addr, 16'hFFFF);
        tick();
        chk("wrap_pc_top", bus.inst_pc, 16'hFFFF);
        chk("wrap_data_top", bus.inst_data, 16'h5A5A);
        tick();
        chk("wrap_pc_zero", bus.inst_pc, 16'h0000);
        chk("wrap_data_zero", bus.inst_data, 16'hA5A5);
        chk("wrap_valid", bus.inst_valid, 1);

        // Asynchronous reset mid-access with the slot valid
        lat = 3;
        #1;
        chk("mid_req", bus.rom_req, 1);
        chk("mid_addr", bus.rom_addr, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("async_valid", bus.inst_valid, 0);
        chk("async_req", bus.rom_req, 0);
        chk("async_data", bus.inst_data, 0);
        force_ack = 1'b1;
        tick();
        chk("late_ack_valid", bus.inst_valid, 0);
        chk("late_ack_data", bus.inst_data, 0);
        force_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rerun_req", bus.rom_req, 1);
        chk("rerun_addr", bus.rom_addr, 16'h0000);
        lat = 0;
        tick();
        chk("rerun_valid", bus.inst_valid, 1);
        chk("rerun_pc", bus.inst_pc, 16'h0000);
        chk("rerun_data", bus.inst_data, 16'hA5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
